// File: rtl/local_mem_pixel_param_pkg.sv
// pixel_mem_pkg: shared types and helpers for the parametrised pixel local memory.
//   ld_state_t  - stream loader states
//   clog2_min1  - ceil(log2(n)), never less than 1 (usable in localparams)
//   in_frame    - signed bounds check of a (row, col) coordinate against an H x W frame
package pixel_mem_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic in_frame(input int row, input int col, input int h, input int w);
        return (row >= 0) && (row < h) && (col >= 0) && (col < w);
    endfunction

endpackage

// File: rtl/local_mem_pixel_param_if.sv
// local_mem_pixel_param_if: loader, direct-write and read bus of the pixel memory.
//   master - the writer / window fetcher side (drives requests, sees status)
//   slave  - the memory side
// Widths follow the frame geometry: rd_row/rd_col are signed with one spare bit
// so that negative (padding) coordinates can be expressed.
interface local_mem_pixel_param_if #(
    parameter int CH     = 3,
    parameter int DW     = 16,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 16
);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int CNT_W = $clog2(CH * IMG_W * IMG_H + 1);

    logic              load_start;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic              dir_wr_en;
    logic [ADDR_W-1:0] dir_wr_addr;
    logic [DW-1:0]     dir_wr_data;
    logic              rd_en;
    logic [RW:0]       rd_row;
    logic [CW:0]       rd_col;
    logic [CH*DW-1:0]  rd_data;
    logic              rd_valid;
    logic              frame_done;
    logic [CNT_W-1:0]  load_cnt;

    modport master (
        output load_start, wr_valid, wr_data, dir_wr_en, dir_wr_addr, dir_wr_data,
               rd_en, rd_row, rd_col,
        input  wr_ready, rd_data, rd_valid, frame_done, load_cnt
    );

    modport slave (
        input  load_start, wr_valid, wr_data, dir_wr_en, dir_wr_addr, dir_wr_data,
               rd_en, rd_row, rd_col,
        output wr_ready, rd_data, rd_valid, frame_done, load_cnt
    );

endinterface

// File: rtl/local_mem_pixel_param_load_ctrl.sv
// pixel_load_ctrl: stream loader for the pixel memory.
//   clk, rst        - clock, asynchronous active-low reset
//   load_start      - restart: pointer to 0, frame_done cleared, enter LOAD
//   wr_valid        - stream beat offered
//   dir_wr_en       - direct write in progress (blocks the stream this cycle)
//   wr_ready        - beat accepted when wr_valid & wr_ready
//   ld_we/ld_ch/ld_pix - storage write request for the accepted beat
//   load_cnt        - beats accepted since load_start
//   frame_done      - all CH*NPIX beats received
// Beats arrive channel-major, row-major inside a channel, so the pointer splits
// into channel = cnt / NPIX and pixel = cnt % NPIX.
module pixel_load_ctrl
    import pixel_mem_pkg::*;
#(
    parameter int CH    = 3,
    parameter int NPIX  = 1024,
    parameter int CHW   = 2,
    parameter int PIXW  = 10,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             wr_valid,
    input  logic             dir_wr_en,
    output logic             wr_ready,
    output logic             ld_we,
    output logic [CHW-1:0]   ld_ch,
    output logic [PIXW-1:0]  ld_pix,
    output logic [CNT_W-1:0] load_cnt,
    output logic             frame_done
);
    localparam int               NBEAT  = CH * NPIX;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(NBEAT - 1);
    localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);

    ld_state_t        state_q, state_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        frame_done_d = frame_done_q;
        // load_start wins over a beat offered in the same cycle.
        wr_ready     = (state_q == LD_LOAD) && !dir_wr_en && !load_start;
        accept       = wr_ready && wr_valid;

        if (load_start) begin
            state_d      = LD_LOAD;
            load_cnt_d   = '0;
            frame_done_d = 1'b0;
        end else if (accept) begin
            load_cnt_d = load_cnt_q + 1'b1;
            if (load_cnt_q == LAST) begin
                state_d      = LD_DONE;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= LD_IDLE;
            load_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ld_we      = accept;
    assign ld_ch      = CHW'(load_cnt_q / NPIX_C);
    assign ld_pix     = PIXW'(load_cnt_q % NPIX_C);
    assign load_cnt   = load_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/local_mem_pixel_param.sv
// local_mem_pixel_param: one CH-channel IMG_H x IMG_W frame buffer for the conv datapath.
//   clk, rst - clock, asynchronous active-low reset (memory contents are kept)
//   bus      - slave side of local_mem_pixel_param_if:
//              stream loader (load_start / wr_valid / wr_ready / wr_data / load_cnt / frame_done),
//              direct write (dir_wr_en / dir_wr_addr = {ch,row,col} / dir_wr_data),
//              read (rd_en / signed rd_row,rd_col -> rd_valid / rd_data one cycle later).
// Out-of-frame reads return zero, which the window fetcher uses as padding.
module local_mem_pixel_param
    import pixel_mem_pkg::*;
#(
    parameter int CH     = 3,
    parameter int DW     = 16,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    local_mem_pixel_param_if.slave  bus
);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int CHW   = clog2_min1(CH);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PIXW  = clog2_min1(NPIX);
    localparam int CNT_W = $clog2(CH * NPIX + 1);

    logic            ld_we;
    logic [CHW-1:0]  ld_ch;
    logic [PIXW-1:0] ld_pix;

    pixel_load_ctrl #(
        .CH(CH), .NPIX(NPIX), .CHW(CHW), .PIXW(PIXW), .CNT_W(CNT_W)
    ) u_load_ctrl (
        .clk        (clk),
        .rst        (rst),
        .load_start (bus.load_start),
        .wr_valid   (bus.wr_valid),
        .dir_wr_en  (bus.dir_wr_en),
        .wr_ready   (bus.wr_ready),
        .ld_we      (ld_we),
        .ld_ch      (ld_ch),
        .ld_pix     (ld_pix),
        .load_cnt   (bus.load_cnt),
        .frame_done (bus.frame_done)
    );

    // Direct-write decode and single write port arbitration.
    logic [CW-1:0]   dir_col;
    logic [RW-1:0]   dir_row;
    logic [CHW-1:0]  dir_ch;
    logic            dir_ok;
    logic            we;
    logic [CHW-1:0]  we_ch;
    logic [PIXW-1:0] we_pix;
    logic [DW-1:0]   we_data;

    always_comb begin
        dir_col = bus.dir_wr_addr[CW-1:0];
        dir_row = bus.dir_wr_addr[CW +: RW];
        dir_ch  = bus.dir_wr_addr[CW+RW +: CHW];
        // Out-of-range targets are dropped; the stream is still held off that cycle.
        dir_ok  = bus.dir_wr_en && (int'(dir_ch) < CH) &&
                  in_frame(int'(dir_row), int'(dir_col), IMG_H, IMG_W);
        // The loader never accepts while dir_wr_en is high, so dir_wr_en selects the source.
        we      = dir_ok || ld_we;
        if (bus.dir_wr_en) begin
            we_ch   = dir_ch;
            we_pix  = PIXW'(int'(dir_row) * IMG_W + int'(dir_col));
            we_data = bus.dir_wr_data;
        end else begin
            we_ch   = ld_ch;
            we_pix  = ld_pix;
            we_data = bus.wr_data;
        end
    end

    // Read address; out-of-frame coordinates park on pixel 0 and are zeroed later.
    logic            rd_in;
    logic [PIXW-1:0] rd_pix;
    logic [CH*DW-1:0] rd_word;

    always_comb begin
        rd_in  = in_frame(int'($signed(bus.rd_row)), int'($signed(bus.rd_col)), IMG_H, IMG_W);
        rd_pix = '0;
        if (rd_in)
            rd_pix = PIXW'(int'($signed(bus.rd_row)) * IMG_W + int'($signed(bus.rd_col)));
    end

    // One array per channel: a beat touches one channel, a read returns all of them.
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [DW-1:0] mem [NPIX];
        logic          hit;

        assign hit = we && (we_ch == CHW'(gi));

        always_ff @(posedge clk) begin
            if (hit)
                mem[we_pix] <= we_data;
        end

        // Write-first: a same-cycle write to the pixel being read is forwarded.
        assign rd_word[gi*DW +: DW] = (hit && (we_pix == rd_pix)) ? we_data : mem[rd_pix];
    end

    logic             rd_valid_q, rd_valid_d;
    logic [CH*DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = (bus.rd_en && rd_in) ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_local_mem_pixel_param.sv
module tb_local_mem_pixel_param;

    localparam int CH = 3, DW = 16, IMG_W = 32, IMG_H = 32, ADDR_W = 16;
    localparam int NBEAT = CH * IMG_W * IMG_H;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    local_mem_pixel_param_if #(.CH(CH), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) bus ();

    local_mem_pixel_param #(.CH(CH), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input int r, input int c);
        bus.rd_en  = 1'b1;
        bus.rd_row = 6'(r);
        bus.rd_col = 6'(c);
    endtask

    // Offer n beats with data base+k; returns how many were accepted within the cycle budget.
    task automatic stream(input int n, input int base, output int got);
        int  cyc;
        logic acc;
        got = 0;
        cyc = 0;
        bus.wr_valid = 1'b1;
        while (got < n && cyc < n + 100) begin
            bus.wr_data = 16'(base + got);
            #1;
            acc = bus.wr_ready;
            tick();
            if (acc) got++;
            cyc++;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.wr_valid = 1'b1;
        bus.rd_en    = 1'b1;
        repeat (2) tick();
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_ready); end
        vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        vectors++; if (bus.rd_data !== 48'd0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        vectors++; if (bus.load_cnt !== 12'd0) begin miscompares++; $display("FAIL reset_load_cnt: got %0d expected 0", bus.load_cnt); end
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        tick();
        // Idle after reset: stream not accepted until load_start.
        bus.wr_valid = 1'b1;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL idle_wr_ready: got %b expected 0", bus.wr_ready); end
        bus.wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream_load();
        int got;
        logic [47:0] exp;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        stream(NBEAT - 1, 0, got);
        vectors++; if (got != NBEAT - 1) begin miscompares++; $display("FAIL stream_timeout: got %0d beats expected %0d", got, NBEAT - 1); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL done_before_last: got %b expected 0", bus.frame_done); end
        vectors++; if (bus.load_cnt !== 12'd3071) begin miscompares++; $display("FAIL cnt_before_last: got %0d expected 3071", bus.load_cnt); end
        stream(1, NBEAT - 1, got);
        vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_done: got %b expected 1", bus.frame_done); end
        vectors++; if (bus.load_cnt !== 12'd3072) begin miscompares++; $display("FAIL load_cnt_full: got %0d expected 3072", bus.load_cnt); end
        // Extra beats in DONE are ignored.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hFFFF;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL done_wr_ready: got %b expected 0", bus.wr_ready); end
        tick();
        bus.wr_valid = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd3072) begin miscompares++; $display("FAIL done_cnt_hold: got %0d expected 3072", bus.load_cnt); end
        rd_req(5, 7);
        tick();
        bus.rd_en = 1'b0;
        exp = {16'd2215, 16'd1191, 16'd167};
        vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL read_5_7_valid: got %b expected 1", bus.rd_valid); end
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL read_5_7: got %h expected %h", bus.rd_data, exp); end
        tick();
    endtask

    task automatic test_out_of_frame();
        int rows [3] = '{-1, 0, 32};
        int cols [3] = '{0, 32, 31};
        for (int k = 0; k < 3; k++) begin
            rd_req(rows[k], cols[k]);
            tick();
            vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL oof_valid_%0d: got %b expected 1", k, bus.rd_valid); end
            vectors++; if (bus.rd_data !== 48'd0) begin miscompares++; $display("FAIL oof_data_%0d: got %h expected 0", k, bus.rd_data); end
        end
        bus.rd_en = 1'b0;
        tick();
        vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rd_valid: got %b expected 0", bus.rd_valid); end
        vectors++; if (bus.rd_data !== 48'd0) begin miscompares++; $display("FAIL idle_rd_data: got %h expected 0", bus.rd_data); end
    endtask

    task automatic test_direct_write();
        logic [47:0] exp;
        bus.dir_wr_en   = 1'b1;
        bus.dir_wr_addr = 16'h0464;
        bus.dir_wr_data = 16'hBEEF;
        tick();
        bus.dir_wr_en = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd3072) begin miscompares++; $display("FAIL dir_cnt_hold: got %0d expected 3072", bus.load_cnt); end
        vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("FAIL dir_done_hold: got %b expected 1", bus.frame_done); end
        rd_req(3, 4);
        tick();
        bus.rd_en = 1'b0;
        exp = {16'd2148, 16'hBEEF, 16'd100};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL dir_write_3_4: got %h expected %h", bus.rd_data, exp); end
        // ch = 3 does not exist: dropped.
        bus.dir_wr_en   = 1'b1;
        bus.dir_wr_addr = 16'h0C64;
        bus.dir_wr_data = 16'hDEAD;
        tick();
        bus.dir_wr_en = 1'b0;
        rd_req(3, 4);
        tick();
        bus.rd_en = 1'b0;
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL dir_bad_ch: got %h expected %h", bus.rd_data, exp); end
        tick();
    endtask

    task automatic test_collision();
        logic [47:0] exp;
        bus.dir_wr_en   = 1'b1;
        bus.dir_wr_addr = 16'h0000;
        bus.dir_wr_data = 16'h1234;
        rd_req(0, 0);
        tick();
        bus.dir_wr_en = 1'b0;
        exp = {16'd2048, 16'd1024, 16'h1234};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL collision_bypass: got %h expected %h", bus.rd_data, exp); end
        tick();
        bus.rd_en = 1'b0;
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL collision_stored: got %h expected %h", bus.rd_data, exp); end
        tick();
    endtask

    task automatic test_dir_priority();
        int got;
        logic [47:0] exp;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd0) begin miscompares++; $display("FAIL restart_cnt: got %0d expected 0", bus.load_cnt); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b expected 0", bus.frame_done); end
        stream(5, 16'h7000, got);
        vectors++; if (got != 5) begin miscompares++; $display("FAIL prio_stream_timeout: got %0d beats expected 5", got); end
        // Direct write to ch2 (31,31) while beat 5 is offered.
        bus.wr_valid    = 1'b1;
        bus.wr_data     = 16'h7005;
        bus.dir_wr_en   = 1'b1;
        bus.dir_wr_addr = 16'h0BFF;
        bus.dir_wr_data = 16'h5A5A;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL prio_wr_ready: got %b expected 0", bus.wr_ready); end
        tick();
        bus.dir_wr_en = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd5) begin miscompares++; $display("FAIL prio_cnt_hold: got %0d expected 5", bus.load_cnt); end
        #1;
        vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL resume_wr_ready: got %b expected 1", bus.wr_ready); end
        tick();
        vectors++; if (bus.load_cnt !== 12'd6) begin miscompares++; $display("FAIL resume_cnt: got %0d expected 6", bus.load_cnt); end
        // Beat 6 with a same-cycle read of its pixel: stream write is forwarded too.
        bus.wr_data = 16'h7006;
        rd_req(0, 6);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd7) begin miscompares++; $display("FAIL beat6_cnt: got %0d expected 7", bus.load_cnt); end
        exp = {16'd2054, 16'd1030, 16'h7006};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL stream_bypass_0_6: got %h expected %h", bus.rd_data, exp); end
        rd_req(0, 4);
        tick();
        exp = {16'd2052, 16'd1028, 16'h7004};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL read_0_4: got %h expected %h", bus.rd_data, exp); end
        rd_req(0, 5);
        tick();
        exp = {16'd2053, 16'd1029, 16'h7005};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL read_0_5: got %h expected %h", bus.rd_data, exp); end
        rd_req(31, 31);
        tick();
        bus.rd_en = 1'b0;
        exp = {16'h5A5A, 16'd2047, 16'd1023};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL read_31_31: got %h expected %h", bus.rd_data, exp); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        int got;
        logic [47:0] exp;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        stream(100, 16'h3000, got);
        vectors++; if (got != 100) begin miscompares++; $display("FAIL mid_stream_timeout: got %0d beats expected 100", got); end
        rd_req(0, 0);
        tick();
        bus.rd_en = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd100) begin miscompares++; $display("FAIL mid_cnt: got %0d expected 100", bus.load_cnt); end
        vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL mid_rd_valid: got %b expected 1", bus.rd_valid); end
        bus.wr_valid = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL async_wr_ready: got %b expected 0", bus.wr_ready); end
        vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL async_rd_valid: got %b expected 0", bus.rd_valid); end
        vectors++; if (bus.rd_data !== 48'd0) begin miscompares++; $display("FAIL async_rd_data: got %h expected 0", bus.rd_data); end
        vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL async_frame_done: got %b expected 0", bus.frame_done); end
        vectors++; if (bus.load_cnt !== 12'd0) begin miscompares++; $display("FAIL async_load_cnt: got %0d expected 0", bus.load_cnt); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL post_rst_wr_ready: got %b expected 0", bus.wr_ready); end
        repeat (2) tick();
        vectors++; if (bus.load_cnt !== 12'd0) begin miscompares++; $display("FAIL post_rst_cnt: got %0d expected 0", bus.load_cnt); end
        bus.wr_valid = 1'b0;
        // Partially loaded data survives reset: ch0 pixel 34 = beat 34.
        rd_req(1, 2);
        tick();
        bus.rd_en = 1'b0;
        exp = {16'd2082, 16'd1058, 16'h3022};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL kept_1_2: got %h expected %h", bus.rd_data, exp); end
        // load_start alongside wr_valid: that beat is not taken.
        bus.load_start = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_data    = 16'h4444;
        #1;
        vectors++; if (bus.wr_ready !== 1'b0) begin miscompares++; $display("FAIL start_beat_ready: got %b expected 0", bus.wr_ready); end
        tick();
        bus.load_start = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd0) begin miscompares++; $display("FAIL start_beat_cnt: got %0d expected 0", bus.load_cnt); end
        bus.wr_data = 16'h5555;
        #1;
        vectors++; if (bus.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reload_ready: got %b expected 1", bus.wr_ready); end
        tick();
        bus.wr_valid = 1'b0;
        vectors++; if (bus.load_cnt !== 12'd1) begin miscompares++; $display("FAIL reload_cnt: got %0d expected 1", bus.load_cnt); end
        rd_req(0, 0);
        tick();
        bus.rd_en = 1'b0;
        exp = {16'd2048, 16'd1024, 16'h5555};
        vectors++; if (bus.rd_data !== exp) begin miscompares++; $display("FAIL reload_0_0: got %h expected %h", bus.rd_data, exp); end
        tick();
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b0;
        bus.load_start  = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.dir_wr_en   = 1'b0;
        bus.dir_wr_addr = '0;
        bus.dir_wr_data = '0;
        bus.rd_en       = 1'b0;
        bus.rd_row      = '0;
        bus.rd_col      = '0;

        test_reset();
        test_stream_load();
        test_out_of_frame();
        test_direct_write();
        test_collision();
        test_dir_priority();
        test_reset_mid_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/local_mem_pixel_param.md
Name: local_mem_pixel_param

Overview:
Parametrised successor to the fixed 3-channel, 32x32 pixel local memory for the CNN1 datapath. It holds one CH-channel IMG_H x IMG_W input frame and supports two write paths:
- a valid/ready streaming loader with an auto-incrementing pointer and a frame-done flag;
- a direct addressed write path.

Reads are by signed (row, col) coordinate, return all channels of one pixel, and have 1-cycle registered latency. Out-of-frame coordinates return zero, which gives free convolution padding. The block sits between the DMA/wrapper writer and the conv window fetcher.

Parameters:
CH, 3, number of channels per pixel
DW, 16, bits per channel word
IMG_W, 32, frame width in pixels
IMG_H, 32, frame height in pixels
ADDR_W, 16, width of direct write address bus

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
load_start  in  1  restart stream loader: pointer to 0, clear frame_done
wr_valid  in  1  stream beat valid
wr_ready  out  1  stream beat accepted when wr_valid & wr_ready
wr_data  in  DW  stream beat data
dir_wr_en  in  1  direct write strobe
dir_wr_addr  in  ADDR_W  direct address, low bits {ch, row, col}
dir_wr_data  in  DW  direct write data
rd_en  in  1  read request
rd_row  in  RW+1  signed row coordinate
rd_col  in  CW+1  signed col coordinate
rd_data  out  CH*DW  channel c at bits [c*DW +: DW]
rd_valid  out  1  rd_data valid, 1 cycle after rd_en
frame_done  out  1  full frame streamed in
load_cnt  out  $clog2(CH*IMG_W*IMG_H+1)  beats accepted since load_start

Behaviour:
- Derived localparams: RW=$clog2(IMG_H), CW=$clog2(IMG_W), CHW=max(1,$clog2(CH)), NPIX=IMG_W*IMG_H, NBEAT=CH*NPIX.
- Reset (rst=0, async):
  - loader FSM to IDLE; load_cnt=0; frame_done=0; wr_ready=0; rd_valid=0; rd_data=0.
  - Memory contents are not cleared.
- Loader FSM has three states, IDLE / LOAD / DONE:
  - load_start in any state → LOAD, load_cnt←0, frame_done←0.
  - LOAD: wr_ready = ~dir_wr_en & ~load_start.
  - Each accepted beat writes wr_data to channel load_cnt/NPIX at pixel load_cnt%NPIX (row-major, channel-major order), then load_cnt++.
  - When accepting beat NBEAT-1 → DONE; frame_done=1 from the next cycle.
  - IDLE and DONE: wr_ready=0. Extra wr_valid beats are ignored.
  - load_start in the same cycle as wr_valid: the beat is not accepted; the pointer restarts.
- Direct write:
  - dir_wr_en writes dir_wr_data to {ch,row,col} decoded from dir_wr_addr[CHW+RW+CW-1:0].
  - If ch>=CH, row>=IMG_H or col>=IMG_W, the write is dropped silently.
  - Direct write has priority over stream: it forces wr_ready=0 that cycle.
  - Direct write does not change load_cnt or frame_done.
- Read:
  - rd_en at edge N gives rd_valid=1 and rd_data at edge N+1, fully registered.
  - rd_en=0 gives rd_valid=0 and rd_data=0 next cycle.
  - Back-to-back reads are fully pipelined, one per cycle.
  - Coordinate out of range (rd_row<0, rd_row>=IMG_H, rd_col<0, rd_col>=IMG_W) returns rd_data=0 with rd_valid=1.
- Read/write collision:
  - A same-cycle write (stream or direct) to the pixel being read is write-first: the written channel returns the new value, other channels return stored values.
- Reset mid-load: the loader returns to IDLE, and a new load_start is needed. Partially written data remains.
- Storage is a flop/inferred array [CH][NPIX][DW] with one write port and one read port. No SRAM macro is used, so any parameter set synthesises.

Decomposition:
- Package pixel_mem_pkg:
  - typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;
  - function clog2_min1;
  - function in_frame(row, col, H, W) for the bounds check.
- Sub-module pixel_load_ctrl: owns the FSM, load_cnt, frame_done and wr_ready. It outputs a write enable plus ch/pixel index.
- The top holds storage, the direct-write decode, write arbitration, bypass and the read register.

Test Plan:
- Default params; load_start, then stream 3072 beats with wr_data=beat index → frame_done=1 one cycle after the last beat, load_cnt=3072. Read (5,7) → rd_data={16'd2215,16'd1191,16'd167}.
- Read (-1,0), (0,32) and (32,31) → rd_valid=1 and rd_data=48'd0 each cycle, back-to-back.
- Direct write addr {2'd1,5'd3,5'd4}=0x464 data 0xBEEF, then read (3,4) → bits [31:16]=0xBEEF, other channels unchanged. Addr with ch=3 → no memory change.
- During LOAD, assert dir_wr_en with wr_valid → wr_ready=0 that cycle, load_cnt unchanged. The stream resumes next cycle with no lost or duplicated beat.
- Same-cycle direct write 0x1234 to ch0 (0,0) and rd_en at (0,0) → the next-cycle rd_data[15:0]=0x1234.
- Drop rst to 0 after 100 stream beats → wr_ready, rd_valid, frame_done and load_cnt go to 0 immediately. After release, wr_valid is ignored until load_start. A load_start issued alongside wr_valid does not accept that beat.
